seq_subtractor: RTL and testbench

- Parametrised multi-cycle subtractor: computes diff = a - b - bin over WIDTH bits.
- Processes CHUNK bits per clock, propagating a registered borrow between chunks.
- Successor to the single-bit combinational full subtractor: adds operand width, a chunk size, a start/busy/done handshake, and borrow-out and signed-overflow flags.
- Sits behind a control unit that issues one subtraction at a time and waits for done.

---
 rtl/sub_pkg.sv | 20 ++
 rtl/chunk_subtractor.sv | 24 ++
 rtl/seq_subtractor.sv | 100 ++++++++++
 tb/tb_seq_subtractor.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the chunked sequential subtractor.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/chunk_subtractor.sv
// Combinational CHUNK-bit ripple subtractor built from per-bit full-subtractor cells.
module chunk_subtractor #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             bi,
    output logic [CHUNK-1:0] d,
    output logic             bo
);

    // Borrow chain: br[i] is the borrow into bit i.
    logic [CHUNK:0] br;

    assign br[0] = bi;

    for (genvar i = 0; i < CHUNK; i++) begin : g_cell
        assign d[i]    = x[i] ^ y[i] ^ br[i];
        assign br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
    end

    assign bo = br[CHUNK];

endmodule

// File: rtl/seq_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, CHUNK bits per clock with a
// registered borrow between chunks, start/busy/done handshake and flags.
module seq_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (clog2(NCHUNK) < 1) ? 1 : clog2(NCHUNK);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
        $error("seq_subtractor: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             borrow;
    logic [CNT_W-1:0] cnt;

    int               base;
    logic [CHUNK-1:0] x_c;
    logic [CHUNK-1:0] y_c;
    logic [CHUNK-1:0] d_c;
    logic             bo_c;

    assign base = int'(cnt) * CHUNK;
    assign x_c  = a_q[base +: CHUNK];
    assign y_c  = b_q[base +: CHUNK];

    chunk_subtractor #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .x (x_c),
        .y (y_c),
        .bi(borrow),
        .d (d_c),
        .bo(bo_c)
    );

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Handshake FSM, operand latching, chunk write-back and final flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    diff[base +: CHUNK] <= d_c;
                    borrow              <= bo_c;
                    cnt                 <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Final chunk carries the result MSB, so the flags settle here.
                        bout  <= bo_c;
                        ovf   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                 (d_c[CHUNK-1] != a_q[WIDTH-1]);
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_subtractor.sv
// Bench for seq_subtractor: three instances (CHUNK 1, 4, 16) share stimulus
// and are checked against an arithmetic reference model.
module tb_seq_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;

    logic        busy1, done1, bout1, ovf1;
    logic        busy4, done4, bout4, ovf4;
    logic        busy16, done16, bout16, ovf16;
    logic [15:0] diff1, diff4, diff16;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_subtractor #(.WIDTH(16), .CHUNK(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1)
    );

    seq_subtractor #(.WIDTH(16), .CHUNK(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
    );

    seq_subtractor #(.WIDTH(16), .CHUNK(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .ovf(ovf16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic; returns {ovf, bout, diff}.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic bi);
        int ux, uy, sx, sy, bb, sr;
        logic [15:0] d;
        logic        bo, ov;
        ux = x;
        uy = y;
        sx = $signed(x);
        sy = $signed(y);
        bb = bi ? 1 : 0;
        d  = 16'(ux - uy - bb);
        bo = (ux < uy + bb);
        sr = sx - sy - bb;
        ov = (sr > 32767) || (sr < -32768);
        return {ov, bo, d};
    endfunction

    task automatic check_res(input string tag, input int nchunk, input int lat,
                             input int nd, input int nb, input logic [15:0] d,
                             input logic bo, input logic ov, input logic [17:0] m);
        chk({tag, "_lat"},   lat, nchunk + 1);
        chk({tag, "_ndone"}, nd, 1);
        chk({tag, "_nbusy"}, nb, nchunk);
        chk({tag, "_diff"},  d,  m[15:0]);
        chk({tag, "_bout"},  bo, m[16]);
        chk({tag, "_ovf"},   ov, m[17]);
    endtask

    // One start pulse; watch all three instances for a bounded number of cycles.
    task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                         input string tag);
        int lat1 = 0, lat4 = 0, lat16 = 0;
        int nd1 = 0, nd4 = 0, nd16 = 0;
        int nb1 = 0, nb4 = 0, nb16 = 0;
        logic [17:0] m;
        a = ia; b = ib; bin = ibin; start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                start = 1'b0;
                a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
            end
            if (done1)  begin nd1++;  if (lat1 == 0)  lat1 = k;  end
            if (done4)  begin nd4++;  if (lat4 == 0)  lat4 = k;  end
            if (done16) begin nd16++; if (lat16 == 0) lat16 = k; end
            if (busy1)  nb1++;
            if (busy4)  nb4++;
            if (busy16) nb16++;
        end
        m = model(ia, ib, ibin);
        check_res({tag, "/c1"},  16, lat1,  nd1,  nb1,  diff1,  bout1,  ovf1,  m);
        check_res({tag, "/c4"},  4,  lat4,  nd4,  nb4,  diff4,  bout4,  ovf4,  m);
        check_res({tag, "/c16"}, 1,  lat16, nd16, nb16, diff16, bout16, ovf16, m);
    endtask

    task automatic directed(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                            input logic [15:0] ed, input logic ebo, input logic eov,
                            input string tag);
        do_op(ia, ib, ibin, tag);
        chk({tag, "_k_diff"}, diff4, ed);
        chk({tag, "_k_bout"}, bout4, ebo);
        chk({tag, "_k_ovf"},  ovf4, eov);
    endtask

    logic [15:0] ha [0:29];
    logic [15:0] hb [0:29];
    logic        hbin [0:29];

    initial begin
        logic [17:0] m;
        int          nd;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_diff", diff4, 0);
        chk("rst_bout", bout4, 0);
        chk("rst_ovf",  ovf4, 0);
        chk("rst_diff1", diff1, 0);
        chk("rst_diff16", diff16, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        directed(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, "basic");
        directed(16'h1000, 16'h0000, 1'b1, 16'h0FFF, 1'b0, 1'b0, "ripple");
        directed(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, "under");
        directed(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, "ovf_neg");
        directed(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "allones");
        directed(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, "ovf_pos");

        // Reset in the 2nd RUN cycle; flags were left at 1 by the previous op.
        a = 16'hABCD; b = 16'h1234; bin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy4, 0);
        chk("mid_rst_done", done4, 0);
        chk("mid_rst_diff", diff4, 0);
        chk("mid_rst_bout", bout4, 0);
        chk("mid_rst_ovf",  ovf4, 0);
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done4) nd++;
        end
        chk("mid_rst_nodone", nd, 0);
        directed(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, "after_rst");

        // start held high, operands change every cycle: accepts at edges 0,5,10,...
        nd = 0;
        start = 1'b1;
        for (int n = 0; n < 30; n++) begin
            ha[n] = 16'($urandom); hb[n] = 16'($urandom); hbin[n] = 1'($urandom);
            a = ha[n]; b = hb[n]; bin = hbin[n];
            @(posedge clk); #1;
            chk("hs_done", done4, (n % 5) == 4);
            chk("hs_busy", busy4, (n % 5) != 4);
            if (done4) nd++;
            if ((n % 5) == 4) begin
                m = model(ha[n-4], hb[n-4], hbin[n-4]);
                chk("hs_diff", diff4, m[15:0]);
                chk("hs_bout", bout4, m[16]);
                chk("hs_ovf",  ovf4, m[17]);
            end
        end
        chk("hs_ndone", nd, 6);
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        for (int i = 0; i < 1000; i++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), "rnd");
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
